interrupt_ctrl: RTL and testbench

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

---
 rtl/interrupt_ctrl.sv | 112 +++++++++++
 tb/tb_interrupt_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: machine-mode interrupt CSRs, pending/enable logic and the
// trap-entry / MRET redirect handshake toward the pipeline front end.
module interrupt_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_interupt,
    input  logic        ext_irq,
    input  logic        instr_valid,
    input  logic [31:0] pc_in,
    input  logic        is_mret,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        redirect_req,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack
);
    typedef enum logic {IDLE, REDIRECT} state_t;
    state_t state, state_nx;
    logic mstatus_mie, mstatus_mpie, mie_mtie, mie_meie, mip_mtip, mip_meip;
    logic [29:0] mtvec_base, mepc_base;
    logic [31:0] mcause;
    logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mip;
    logic ext_pend, take_mret, take_trap;
    logic unused_pc;
    assign unused_pc  = ^pc_in[1:0];
    assign wr_mstatus = csr_we && csr_addr == 12'h300;
    assign wr_mie     = csr_we && csr_addr == 12'h304;
    assign wr_mtvec   = csr_we && csr_addr == 12'h305;
    assign wr_mepc    = csr_we && csr_addr == 12'h341;
    assign wr_mcause  = csr_we && csr_addr == 12'h342;
    assign wr_mip     = csr_we && csr_addr == 12'h344;
    assign ext_pend   = mip_meip && mie_meie;
    // MRET wins over a coincident trap; the interrupt is retaken after the redirect
    assign take_mret  = state == IDLE && instr_valid && is_mret;
    assign take_trap  = state == IDLE && instr_valid && !is_mret && mstatus_mie &&
                        (ext_pend || (mip_mtip && mie_mtie));
    assign redirect_req = state == REDIRECT;
    always_comb begin
        state_nx = state;
        if (take_mret || take_trap)
            state_nx = REDIRECT;
        else if (state == REDIRECT && redirect_ack)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mip_mtip     <= 1'b0;
            mip_meip     <= 1'b0;
            mtvec_base   <= RESET_MTVEC[31:2];
            mepc_base    <= 30'd0;
            mcause       <= 32'd0;
            redirect_pc  <= 32'd0;
        end else begin
            mip_meip <= ext_irq;
            if (timer_interupt)
                mip_mtip <= 1'b1;
            else if (wr_mip && !csr_wdata[7])
                mip_mtip <= 1'b0;
            if (wr_mie) begin
                mie_mtie <= csr_wdata[7];
                mie_meie <= csr_wdata[11];
            end
            if (wr_mtvec)
                mtvec_base <= csr_wdata[31:2];
            if (wr_mstatus) begin
                mstatus_mie  <= csr_wdata[3];
                mstatus_mpie <= csr_wdata[7];
            end
            if (wr_mepc)
                mepc_base <= csr_wdata[31:2];
            if (wr_mcause)
                mcause <= csr_wdata;
            // hardware updates come last so they override a same-cycle CSR write
            if (take_trap) begin
                mepc_base    <= pc_in[31:2];
                mcause       <= ext_pend ? 32'h8000_000B : 32'h8000_0007;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                redirect_pc  <= {mtvec_base, 2'b00};
            end else if (take_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
                redirect_pc  <= {mepc_base, 2'b00};
            end
        end
    end
    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
            12'h304: csr_rdata = {20'd0, mie_meie, 3'd0, mie_mtie, 7'd0};
            12'h305: csr_rdata = {mtvec_base, 2'b00};
            12'h341: csr_rdata = {mepc_base, 2'b00};
            12'h342: csr_rdata = mcause;
            12'h344: csr_rdata = {20'd0, mip_meip, 3'd0, mip_mtip, 7'd0};
            default: csr_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: table-driven CSR checks, directed trap/MRET/handshake
// sequences and a randomized run against a word-level reference model.
module tb_interrupt_ctrl;
    localparam logic [31:0] RMTVEC = 32'h0000_0200;
    logic        clk = 1'b0, rst = 1'b0;
    logic        timer_interupt = 1'b0, ext_irq = 1'b0, instr_valid = 1'b0, is_mret = 1'b0;
    logic [31:0] pc_in = 32'd0, csr_wdata = 32'd0;
    logic        csr_we = 1'b0, redirect_ack = 1'b0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_rdata, redirect_pc;
    logic        redirect_req;
    int total = 0, bad = 0;

    interrupt_ctrl #(.RESET_MTVEC(RMTVEC)) dut (
        .clk(clk), .rst(rst), .timer_interupt(timer_interupt), .ext_irq(ext_irq),
        .instr_valid(instr_valid), .pc_in(pc_in), .is_mret(is_mret), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .redirect_req(redirect_req), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack)
    );

    always #5 clk = ~clk;

    // reference model: architectural CSR words as software would see them
    logic [31:0] m_status, m_ie, m_tvec, m_epc, m_cause, m_ip, m_rpc;
    bit m_busy;

    task automatic model_reset;
        m_status = 0; m_ie = 0; m_tvec = RMTVEC; m_epc = 0; m_cause = 0; m_ip = 0;
        m_rpc = 0; m_busy = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return m_status;
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h344: return m_ip;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step;
        logic [31:0] ns = m_status, nie = m_ie, ntv = m_tvec, nep = m_epc, nc = m_cause;
        logic [31:0] nip = m_ip, nrpc = m_rpc;
        bit nb = m_busy;
        bit pend_ext = m_ip[11] && m_ie[11];
        bit pend_any = (m_ip & m_ie & 32'h880) != 0;
        if (csr_we)
            case (csr_addr)
                12'h300: ns = csr_wdata & 32'h88;
                12'h304: nie = csr_wdata & 32'h880;
                12'h305: ntv = csr_wdata & ~32'd3;
                12'h341: nep = csr_wdata & ~32'd3;
                12'h342: nc = csr_wdata;
                default: ;
            endcase
        nip[11] = ext_irq;
        if (timer_interupt) nip[7] = 1'b1;
        else if (csr_we && csr_addr == 12'h344 && !csr_wdata[7]) nip[7] = 1'b0;
        if (!m_busy && instr_valid && is_mret) begin
            ns = 32'h80 | (m_status[7] ? 32'h8 : 32'h0);
            nrpc = m_epc;
            nb = 1;
        end else if (!m_busy && instr_valid && m_status[3] && pend_any) begin
            nep = pc_in & ~32'd3;
            nc = pend_ext ? 32'h8000_000B : 32'h8000_0007;
            ns = 32'h80;
            nrpc = m_tvec;
            nb = 1;
        end else if (m_busy && redirect_ack) begin
            nb = 0;
        end
        m_status = ns; m_ie = nie; m_tvec = ntv; m_epc = nep; m_cause = nc; m_ip = nip;
        m_rpc = nrpc; m_busy = nb;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        #1;
        chk("rdata_model", csr_rdata, model_read(csr_addr));
        model_step();
        @(posedge clk); #1;
        chk("req_model", {31'd0, redirect_req}, {31'd0, m_busy});
        chk("rpc_model", redirect_pc, m_rpc);
    endtask

    task automatic clr;
        timer_interupt = 0; instr_valid = 0; is_mret = 0; csr_we = 0; redirect_ack = 0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_we = 0; csr_addr = a; #1;
        chk(name, csr_rdata, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1; csr_addr = a; csr_wdata = d;
        step();
        csr_we = 0;
    endtask

    typedef struct {logic [11:0] a; logic [31:0] wd; logic [31:0] exp;} vec_t;
    vec_t vt[10];
    logic [11:0] addrs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{12'h300, 32'hFFFF_FFFF, 32'h88};
        vt[1] = '{12'h300, 32'h0,         32'h0};
        vt[2] = '{12'h304, 32'hFFFF_FFFF, 32'h880};
        vt[3] = '{12'h304, 32'h0,         32'h0};
        vt[4] = '{12'h305, 32'h0000_0103, 32'h100};
        vt[5] = '{12'h341, 32'h0000_0047, 32'h44};
        vt[6] = '{12'h342, 32'h1234_5678, 32'h1234_5678};
        vt[7] = '{12'h344, 32'hFFFF_FFFF, 32'h0};
        vt[8] = '{12'h123, 32'hFFFF_FFFF, 32'h0};
        vt[9] = '{12'h341, 32'h0,         32'h0};
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", {31'd0, redirect_req}, 32'd0);
        chk("reset_rpc", redirect_pc, 32'd0);
        rd("reset_mtvec", 12'h305, RMTVEC);
        rd("reset_mstatus", 12'h300, 32'd0);
        rst = 1;
        // CSR write/readback masking
        for (int i = 0; i < 10; i++) begin
            csr_wr(vt[i].a, vt[i].wd);
            rd("csr_table", vt[i].a, vt[i].exp);
        end
        // basic timer trap
        csr_wr(12'h304, 32'h80);
        csr_wr(12'h300, 32'h8);
        timer_interupt = 1; step(); clr();
        rd("mtip_set", 12'h344, 32'h80);
        instr_valid = 1; pc_in = 32'h40; step(); clr();
        chk("trap_req", {31'd0, redirect_req}, 32'd1);
        chk("trap_pc", redirect_pc, 32'h100);
        rd("trap_mepc", 12'h341, 32'h40);
        rd("trap_mcause", 12'h342, 32'h8000_0007);
        rd("trap_mstatus", 12'h300, 32'h80);
        redirect_ack = 1; step(); clr();
        chk("ack_drop", {31'd0, redirect_req}, 32'd0);
        // MIE=0 blocks the pending timer until software re-enables
        instr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mie0_notrap", {31'd0, redirect_req}, 32'd0);
        end
        clr();
        csr_wr(12'h300, 32'h8);
        instr_valid = 1; pc_in = 32'h80; step(); clr();
        chk("reenable_trap", {31'd0, redirect_req}, 32'd1);
        redirect_ack = 1; step(); clr();
        // external beats timer, then MRET, then timer trap
        csr_wr(12'h304, 32'h880);
        ext_irq = 1; step(); step();
        csr_wr(12'h300, 32'h8);
        instr_valid = 1; pc_in = 32'h60; step(); clr();
        rd("ext_mcause", 12'h342, 32'h8000_000B);
        redirect_ack = 1; step(); clr();
        ext_irq = 0; step(); step();
        instr_valid = 1; is_mret = 1; step(); is_mret = 0;
        chk("mret_req", {31'd0, redirect_req}, 32'd1);
        chk("mret_pc", redirect_pc, 32'h60);
        rd("mret_mstatus", 12'h300, 32'h88);
        step();
        chk("redirect_no_trap", redirect_pc, 32'h60);
        redirect_ack = 1; step(); redirect_ack = 0;
        chk("mret_done", {31'd0, redirect_req}, 32'd0);
        step();
        chk("timer_after_mret", {31'd0, redirect_req}, 32'd1);
        rd("timer_mcause", 12'h342, 32'h8000_0007);
        clr();
        // ack withheld for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_req", {31'd0, redirect_req}, 32'd1);
            chk("hold_pc", redirect_pc, 32'h100);
        end
        redirect_ack = 1; step(); clr();
        chk("hold_drop", {31'd0, redirect_req}, 32'd0);
        // timer set wins over software clear
        csr_wr(12'h344, 32'h0);
        rd("mtip_clear", 12'h344, 32'h0);
        timer_interupt = 1; csr_wr(12'h344, 32'h0); clr();
        rd("mtip_set_wins", 12'h344, 32'h80);
        // asynchronous reset mid-handshake
        csr_wr(12'h300, 32'h8);
        instr_valid = 1; step(); clr();
        chk("pre_reset_req", {31'd0, redirect_req}, 32'd1);
        #2 rst = 0; model_reset(); #1;
        chk("async_rst_req", {31'd0, redirect_req}, 32'd0);
        chk("async_rst_pc", redirect_pc, 32'd0);
        rd("rst_mstatus", 12'h300, 32'd0);
        rd("rst_mie", 12'h304, 32'd0);
        rd("rst_mtvec", 12'h305, RMTVEC);
        rd("rst_mepc", 12'h341, 32'd0);
        rd("rst_mcause", 12'h342, 32'd0);
        rd("rst_mip", 12'h344, 32'd0);
        @(posedge clk); #1 rst = 1;
        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            timer_interupt = ($urandom % 8) == 0;
            if (($urandom % 16) == 0) ext_irq = ~ext_irq;
            instr_valid = $urandom % 2;
            is_mret = ($urandom % 6) == 0;
            csr_we = ($urandom % 4) == 0;
            csr_addr = addrs[$urandom % 7];
            csr_wdata = $urandom;
            pc_in = $urandom;
            redirect_ack = ($urandom % 3) == 0;
            step();
        end
        clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
